booth_mult_seq: RTL

Parametrised, sequential radix-4 Booth multiplier with signed/unsigned mode and valid/ready handshakes on both sides. It replaces the fixed 8x8 combinational Booth/CLA multiplier wherever wider operands or area savings matter more than single-cycle latency. It retires one Booth digit per clock into a shared accumulator. Typical users are the datapath MUL unit and DSP blocks that can tolerate multi-cycle results.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_digit_enc.sv | 43 ++++
 rtl/booth_mult_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: the recoded digit set,
// the controller states and the digit-count helper.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  // WIDTH+2 extended multiplier bits give WIDTH/2+1 overlapping triplets.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: maps one multiplier triplet to a signed digit and forms
// digit*A as an (AW+1)-bit two's-complement partial product.
module booth_digit_enc
  import booth_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic [2:0]    i_triplet,
  input  logic [AW-1:0] i_a,
  output booth_digit_t  o_digit,
  output logic [AW:0]   o_pp
);

  logic [AW:0] w_a1;
  logic [AW:0] w_a2;

  // i_a is already sign/zero-extended, so its top bit is the true sign.
  assign w_a1 = {i_a[AW-1], i_a};
  assign w_a2 = {i_a, 1'b0};

  always_comb begin
    case (i_triplet)
      3'b001, 3'b010: o_digit = POS1;
      3'b011:         o_digit = POS2;
      3'b100:         o_digit = NEG2;
      3'b101, 3'b110: o_digit = NEG1;
      default:        o_digit = ZERO;
    endcase
  end

  always_comb begin
    // NOTE: default assignment first so every path drives o_pp and no latch is inferred.
    o_pp = '0;
    case (o_digit)
      POS1:    o_pp = w_a1;
      POS2:    o_pp = w_a2;
      NEG1:    o_pp = -w_a1;
      NEG2:    o_pp = -w_a2;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock into a shared
// (2*WIDTH+4)-bit accumulator, valid/ready on both sides, synchronous flush.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy
);

  localparam int ITER = iter_count(WIDTH);
  localparam int EW   = WIDTH + 2;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mult_state_t        r_state;
  logic [EW-1:0]      r_a;
  logic [EW-1:0]      r_b;
  logic               r_bm1;
  logic [ACCW-1:0]    r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  booth_digit_t       w_digit;
  logic [EW:0]        w_pp;
  logic [ACCW-1:0]    w_pp_shift;
  logic [ACCW-1:0]    w_acc_next;
  logic               w_ext_bit;

  // r_b shifts right two bits per digit, so the live triplet always sits at the bottom.
  booth_digit_enc #(.AW(EW)) u_enc (
    .i_triplet ({r_b[1], r_b[0], r_bm1}),
    .i_a       (r_a),
    .o_digit   (w_digit),
    .o_pp      (w_pp)
  );

  assign w_ext_bit  = signed_mode & a[WIDTH-1];
  assign w_pp_shift = {{(ACCW-EW-1){w_pp[EW]}}, w_pp} << {r_cnt, 1'b0};
  assign w_acc_next = (w_digit == ZERO) ? r_acc : r_acc + w_pp_shift;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bm1       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= {{2{w_ext_bit}}, a};
            r_b        <= {{2{signed_mode & b[WIDTH-1]}}, b};
            r_bm1      <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          r_b   <= {r_b[EW-1], r_b[EW-1], r_b[EW-1:2]};
          r_bm1 <= r_b[1];
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_prod      <= w_acc_next[2*WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign prod      = r_prod;
  assign busy      = r_busy;

endmodule
